// File: rtl/hazard_ctrl_if.sv
// Hazard/forwarding bundle between the D/E/M/W pipeline and hazard_ctrl.
// slave = controller side, master = pipeline side.
interface hazard_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] RsAddrD, RtAddrD;
  logic [ADDR_W-1:0] RsAddrE, RtAddrE;
  logic [DATA_W-1:0] RsDataE, RtDataE;
  logic [ADDR_W-1:0] RAddrE;
  logic              MemReadE, MULOpE, BranchTakenE;
  logic              RegWriteM;
  logic [ADDR_W-1:0] RAddrM;
  logic [DATA_W-1:0] ALUDataM;
  logic              RegWriteW;
  logic [ADDR_W-1:0] RAddrW;
  logic [DATA_W-1:0] RDataW;
  logic [DATA_W-1:0] A, B;
  logic [1:0]        ForwardA, ForwardB;
  logic              StallF, StallD, StallE;
  logic              FlushD, FlushE, FlushM;
  logic              MulBusy;
  logic [31:0]       StallCount, FlushCount;

  modport slave (
    input  RsAddrD, RtAddrD, RsAddrE, RtAddrE, RsDataE, RtDataE, RAddrE,
           MemReadE, MULOpE, BranchTakenE, RegWriteM, RAddrM, ALUDataM,
           RegWriteW, RAddrW, RDataW,
    output A, B, ForwardA, ForwardB, StallF, StallD, StallE,
           FlushD, FlushE, FlushM, MulBusy, StallCount, FlushCount
  );

  modport master (
    output RsAddrD, RtAddrD, RsAddrE, RtAddrE, RsDataE, RtDataE, RAddrE,
           MemReadE, MULOpE, BranchTakenE, RegWriteM, RAddrM, ALUDataM,
           RegWriteW, RAddrW, RDataW,
    input  A, B, ForwardA, ForwardB, StallF, StallD, StallE,
           FlushD, FlushE, FlushM, MulBusy, StallCount, FlushCount
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Forwarding, load-use, branch-flush and multicycle-multiply stall control.
// Define HAZARD_STATS_EN to build the saturating stall/flush counters.
module hazard_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int MUL_LAT = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  hazard_ctrl_if.slave hz
);
  typedef enum logic {IDLE, MUL_BUSY} state_e;

  localparam logic [3:0] LAST = 4'(MUL_LAT - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       mul_stall, lu;
  logic [1:0] fwd_a, fwd_b;

  function automatic logic [1:0] fwd_sel(input logic [ADDR_W-1:0] src,
                                         input logic wr_m, input logic [ADDR_W-1:0] rd_m,
                                         input logic wr_w, input logic [ADDR_W-1:0] rd_w);
    if (wr_m && rd_m != '0 && rd_m == src)      return 2'b10;
    else if (wr_w && rd_w != '0 && rd_w == src) return 2'b01;
    else                                        return 2'b00;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The final residency cycle (cnt==LAST) does not stall; the MULOp leaves E on that edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mul_stall = hz.MULOpE && (cnt_q != LAST);
    case (state_q)
      IDLE: begin
        if (mul_stall) begin
          cnt_d   = cnt_q + 4'd1;
          state_d = MUL_BUSY;
        end
      end
      MUL_BUSY: begin
        if (!hz.MULOpE || cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q + 4'd1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign lu = hz.MemReadE && hz.RAddrE != '0 &&
              (hz.RAddrE == hz.RsAddrD || hz.RAddrE == hz.RtAddrD);

  always_comb begin
    fwd_a = fwd_sel(hz.RsAddrE, hz.RegWriteM, hz.RAddrM, hz.RegWriteW, hz.RAddrW);
    fwd_b = fwd_sel(hz.RtAddrE, hz.RegWriteM, hz.RAddrM, hz.RegWriteW, hz.RAddrW);
    if (rst_i) begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
    end
  end

  assign hz.ForwardA = fwd_a;
  assign hz.ForwardB = fwd_b;
  assign hz.A = (fwd_a == 2'b10) ? hz.ALUDataM : (fwd_a == 2'b01) ? hz.RDataW : hz.RsDataE;
  assign hz.B = (fwd_b == 2'b10) ? hz.ALUDataM : (fwd_b == 2'b01) ? hz.RDataW : hz.RtDataE;

  // Priority: multiply stall > taken branch > load-use.
  assign hz.StallF  = !rst_i && (mul_stall || (!hz.BranchTakenE && lu));
  assign hz.StallD  = !rst_i && (mul_stall || (!hz.BranchTakenE && lu));
  assign hz.StallE  = !rst_i && mul_stall;
  assign hz.FlushM  = !rst_i && mul_stall;
  assign hz.MulBusy = !rst_i && mul_stall;
  assign hz.FlushD  = !rst_i && !mul_stall && hz.BranchTakenE;
  assign hz.FlushE  = !rst_i && !mul_stall && (hz.BranchTakenE || lu);

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (hz.StallF && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
      if ((hz.FlushD || hz.FlushE || hz.FlushM) && flush_cnt_q != '1)
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign hz.StallCount = stall_cnt_q;
  assign hz.FlushCount = flush_cnt_q;
`else
  assign hz.StallCount = '0;
  assign hz.FlushCount = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl with MUL_LAT=4.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.DATA_W(32), .ADDR_W(5)) hz ();
  hazard_ctrl #(.DATA_W(32), .ADDR_W(5), .MUL_LAT(4)) dut (.clk_i(clk), .rst_i(rst), .hz(hz));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    hz.RsAddrD = 0; hz.RtAddrD = 0; hz.RsAddrE = 0; hz.RtAddrE = 0;
    hz.RsDataE = 0; hz.RtDataE = 0; hz.RAddrE = 0;
    hz.MemReadE = 0; hz.MULOpE = 0; hz.BranchTakenE = 0;
    hz.RegWriteM = 0; hz.RAddrM = 0; hz.ALUDataM = 0;
    hz.RegWriteW = 0; hz.RAddrW = 0; hz.RDataW = 0;
  endtask

  initial begin
    logic [31:0] exp_cnt;
    clr();
    // Reset with hazards present: everything forced off, A passes RsDataE.
    hz.MULOpE = 1; hz.BranchTakenE = 1; hz.RegWriteM = 1; hz.RAddrM = 3;
    hz.ALUDataM = 32'h11; hz.RsAddrE = 3; hz.RsDataE = 32'hAA;
    step(); step();
    chk("rst_stallf", hz.StallF, 0);
    chk("rst_flushd", hz.FlushD, 0);
    chk("rst_mulbusy", hz.MulBusy, 0);
    chk("rst_fwda", hz.ForwardA, 0);
    chk("rst_a", hz.A, 32'hAA);
    chk("rst_scnt", hz.StallCount, 0);
    clr();
    rst = 0;
    step();

    // Forwarding priority
    hz.RegWriteM = 1; hz.RAddrM = 3; hz.ALUDataM = 32'h11;
    hz.RegWriteW = 1; hz.RAddrW = 3; hz.RDataW = 32'h22;
    hz.RsAddrE = 3; hz.RsDataE = 32'h33; #1;
    chk("fwd_m_sel", hz.ForwardA, 2'b10);
    chk("fwd_m_a", hz.A, 32'h11);
    hz.RegWriteM = 0; #1;
    chk("fwd_w_sel", hz.ForwardA, 2'b01);
    chk("fwd_w_a", hz.A, 32'h22);
    hz.RegWriteM = 1; hz.RAddrM = 0; hz.RAddrW = 0; hz.RsAddrE = 0; #1;
    chk("fwd_r0_sel", hz.ForwardA, 2'b00);
    chk("fwd_r0_a", hz.A, 32'h33);
    clr(); step();

    // Load-use: one stall cycle, then forward from W
    hz.MemReadE = 1; hz.RAddrE = 5; hz.RtAddrD = 5; #1;
    chk("lu_stallf", hz.StallF, 1);
    chk("lu_stalld", hz.StallD, 1);
    chk("lu_flushe", hz.FlushE, 1);
    chk("lu_stalle", hz.StallE, 0);
    step();
    clr();
    hz.RegWriteW = 1; hz.RAddrW = 5; hz.RDataW = 32'h55; hz.RtAddrE = 5; #1;
    chk("lu_nxt_stallf", hz.StallF, 0);
    chk("lu_fwdb", hz.ForwardB, 2'b01);
    chk("lu_b", hz.B, 32'h55);
    clr(); step();

    // Two back-to-back multiplies: 3 busy, 1 free, twice
    hz.MULOpE = 1; #1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("mul_busy%0d", i), hz.MulBusy, (i % 4 != 3) ? 1 : 0);
      chk($sformatf("mul_stalle%0d", i), hz.StallE, (i % 4 != 3) ? 1 : 0);
      step();
    end
    clr(); step();

    // Priority: multiply beats branch and load-use
    hz.MULOpE = 1; hz.BranchTakenE = 1;
    hz.MemReadE = 1; hz.RAddrE = 7; hz.RsAddrD = 7; #1;
    chk("pri_mul_flushd", hz.FlushD, 0);
    chk("pri_mul_flushe", hz.FlushE, 0);
    chk("pri_mul_stalle", hz.StallE, 1);
    chk("pri_mul_flushm", hz.FlushM, 1);
    hz.MULOpE = 0; #1;
    chk("pri_br_flushd", hz.FlushD, 1);
    chk("pri_br_flushe", hz.FlushE, 1);
    chk("pri_br_stallf", hz.StallF, 0);
    clr(); step();

    // Reset at MulCnt==2, then a full restart
    hz.MULOpE = 1; #1;
    step(); step();
    rst = 1; #1;
    chk("rmul_busy", hz.MulBusy, 0);
    chk("rmul_stalle", hz.StallE, 0);
    chk("rmul_flushm", hz.FlushM, 0);
    chk("rmul_stallf", hz.StallF, 0);
    step();
    rst = 0; #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rmul_after%0d", i), hz.MulBusy, (i < 3) ? 1 : 0);
      step();
    end
    clr();

    // Counters: one load-use stall plus one multiply
    rst = 1; step(); rst = 0; #1;
    chk("cnt_clr_s", hz.StallCount, 0);
    chk("cnt_clr_f", hz.FlushCount, 0);
    hz.MemReadE = 1; hz.RAddrE = 5; hz.RtAddrD = 5;
    step();
    clr();
    hz.MULOpE = 1;
    for (int i = 0; i < 4; i++) step();
    clr(); step();
`ifdef HAZARD_STATS_EN
    exp_cnt = 32'd4;
`else
    exp_cnt = 32'd0;
`endif
    chk("cnt_stall", hz.StallCount, exp_cnt);
    chk("cnt_flush", hz.FlushCount, exp_cnt);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
